// File: rtl/alu181_nibble_seq.sv
`default_nettype none
// ============================================================================
// alu181_nibble_seq : W-bit 74181 operation sequenced one nibble per clock
// Revision 1.0
// ============================================================================
module alu181_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   ready,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  input  logic [3:0]             s_in,
  input  logic                   m_in,
  input  logic                   cin,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_cnb,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cn4b,
  input  logic                   alu_aeb,
  output logic [4*NIBBLES-1:0]   res,
  output logic                   cout,
  output logic                   aeb,
  output logic                   zero,
  output logic                   res_valid,
  input  logic                   res_ack
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic [3:0]      s_q;
  logic            m_q;
  logic            cin_q;
  logic            carry_q;
  logic            aeb_q;
  logic            cout_q;
  logic            ready_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= 4'h0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      aeb_q   <= 1'b0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            s_q     <= s_in;
            m_q     <= m_in;
            cin_q   <= cin;
            k_q     <= '0;
            aeb_q   <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (k_q == KW'(n)) res_q[4*n +: 4] <= alu_f;
          end
          carry_q <= alu_cn4b;
          aeb_q   <= aeb_q & alu_aeb;
          if (k_q == K_LAST) begin
            // The final slice carry becomes the word carry; logic mode has none.
            cout_q  <= ~m_q & ~alu_cn4b;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_DONE: begin
          if (res_ack) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Slice drive is quiet (zero operands, no carry) whenever no nibble is in flight.
  always_comb begin
    alu_a   = 4'h0;
    alu_b   = 4'h0;
    alu_cnb = 1'b1;
    if (state_q == S_RUN) begin
      for (int n = 0; n < NIBBLES; n++) begin
        if (k_q == KW'(n)) begin
          alu_a = a_q[4*n +: 4];
          alu_b = b_q[4*n +: 4];
        end
      end
      alu_cnb = (k_q == '0) ? ~cin_q : carry_q;
    end
  end

  assign alu_s     = s_q;
  assign alu_m     = m_q;
  assign ready     = ready_q;
  assign res_valid = valid_q;
  assign res       = res_q;
  assign cout      = cout_q;
  assign aeb       = aeb_q;
  assign zero      = ~|res_q;

endmodule
`default_nettype wire

// File: tb/tb_alu181_nibble_seq.sv
`default_nettype none
// ============================================================================
// tb_alu181_nibble_seq : sequencer bench with a behavioural 74181 slice
// Revision 1.0
// ============================================================================
module tb_alu181_nibble_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk, rst, start, ready, m_in, cin;
  logic [W-1:0]  a_in, b_in, res;
  logic [3:0]    s_in, alu_a, alu_b, alu_s, alu_f;
  logic          alu_m, alu_cnb, alu_cn4b, alu_aeb;
  logic          cout, aeb, zero, res_valid, res_ack;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0]  exp_res;
  logic          exp_cout, exp_aeb, exp_zero;
  logic [N-1:0]  exp_cy;   // active-high carry into each nibble

  alu181_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .a_in(a_in), .b_in(b_in), .s_in(s_in), .m_in(m_in), .cin(cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cnb(alu_cnb),
    .alu_f(alu_f), .alu_cn4b(alu_cn4b), .alu_aeb(alu_aeb),
    .res(res), .cout(cout), .aeb(aeb), .zero(zero),
    .res_valid(res_valid), .res_ack(res_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit 74181 slice, active-high data
  always_comb begin
    logic [3:0] x, y;
    logic [4:0] t;
    x = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    y = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    t = {1'b0, x} + {1'b0, y} + {4'b0, ~alu_cnb};
    alu_f    = alu_m ? ~(x ^ y) : t[3:0];
    alu_cn4b = ~t[4];
    alu_aeb  = &alu_f;
  end

  // Word-level reference from the 74181 function table
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] s, input logic m, input logic c);
    logic [W-1:0] nb, x, y, lg, ones, lm;
    logic [W:0]   sum, pm;
    nb   = ~b;
    ones = '1;
    case (s)
      4'd0:  begin x = a;       y = '0;     end
      4'd1:  begin x = a | b;   y = '0;     end
      4'd2:  begin x = a | nb;  y = '0;     end
      4'd3:  begin x = ones;    y = '0;     end
      4'd4:  begin x = a;       y = a & nb; end
      4'd5:  begin x = a | b;   y = a & nb; end
      4'd6:  begin x = a;       y = nb;     end
      4'd7:  begin x = a & nb;  y = ones;   end
      4'd8:  begin x = a;       y = a & b;  end
      4'd9:  begin x = a;       y = b;      end
      4'd10: begin x = a | nb;  y = a & b;  end
      4'd11: begin x = a & b;   y = ones;   end
      4'd12: begin x = a;       y = a;      end
      4'd13: begin x = a | b;   y = a;      end
      4'd14: begin x = a | nb;  y = a;      end
      default: begin x = a;     y = ones;   end
    endcase
    case (s)
      4'd0:  lg = ~a;
      4'd1:  lg = ~(a | b);
      4'd2:  lg = ~a & b;
      4'd3:  lg = '0;
      4'd4:  lg = ~(a & b);
      4'd5:  lg = ~b;
      4'd6:  lg = a ^ b;
      4'd7:  lg = a & ~b;
      4'd8:  lg = ~a | b;
      4'd9:  lg = ~(a ^ b);
      4'd10: lg = b;
      4'd11: lg = a & b;
      4'd12: lg = ones;
      4'd13: lg = a | ~b;
      4'd14: lg = a | b;
      default: lg = a;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    for (int i = 0; i < N; i++) begin
      lm = (W'(1) << (4 * i)) - W'(1);
      pm = {1'b0, x & lm} + {1'b0, y & lm} + {{W{1'b0}}, c};
      exp_cy[i] = pm[4 * i];
    end
    exp_res  = m ? lg : sum[W-1:0];
    exp_cout = m ? 1'b0 : sum[W];
    exp_aeb  = &exp_res;
    exp_zero = (exp_res == '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                       input logic m, input logic c, input bit ack_now);
    model(a, b, s, m, c);
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL ready_before_start: got %b want 1", ready); end
    a_in = a; b_in = b; s_in = s; m_in = m; cin = c; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL early_valid k=%0d: got %b want 0", i, res_valid); end
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL ready_in_run k=%0d: got %b want 0", i, ready); end
        n_vec++; if (alu_a !== a[4*i +: 4]) begin n_err++; $display("FAIL alu_a k=%0d: got %h want %h", i, alu_a, a[4*i +: 4]); end
        n_vec++; if (alu_b !== b[4*i +: 4]) begin n_err++; $display("FAIL alu_b k=%0d: got %h want %h", i, alu_b, b[4*i +: 4]); end
        n_vec++; if ({alu_s, alu_m} !== {s, m}) begin n_err++; $display("FAIL alu_sm k=%0d: got %h/%b want %h/%b", i, alu_s, alu_m, s, m); end
        n_vec++; if (alu_cnb !== ~exp_cy[i]) begin n_err++; $display("FAIL alu_cnb k=%0d: got %b want %b", i, alu_cnb, ~exp_cy[i]); end
        step();
      end else begin
        n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL valid_latency: got %b want 1", res_valid); end
        n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL res: got %h want %h", res, exp_res); end
        n_vec++; if (cout !== exp_cout) begin n_err++; $display("FAIL cout: got %b want %b", cout, exp_cout); end
        n_vec++; if (aeb !== exp_aeb) begin n_err++; $display("FAIL aeb: got %b want %b", aeb, exp_aeb); end
        n_vec++; if (zero !== exp_zero) begin n_err++; $display("FAIL zero: got %b want %b", zero, exp_zero); end
        n_vec++; if ({alu_a, alu_b, alu_cnb} !== 9'h001) begin n_err++; $display("FAIL idle_drive: got %h/%h/%b want 0/0/1", alu_a, alu_b, alu_cnb); end
      end
    end
    if (ack_now) begin
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
      n_vec++; if ({ready, res_valid} !== 2'b10) begin n_err++; $display("FAIL after_ack: got ready=%b valid=%b want 1/0", ready, res_valid); end
      n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL res_hold_idle: got %h want %h", res, exp_res); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; res_ack = 1'b1;
    a_in = 16'hFFFF; b_in = 16'hFFFF; s_in = 4'hF; m_in = 1'b1; cin = 1'b1;
    step();
    step();
    n_vec++; if ({ready, res_valid} !== 2'b10) begin n_err++; $display("FAIL reset_hs: got ready=%b valid=%b want 1/0", ready, res_valid); end
    n_vec++; if ({res, cout, aeb, zero} !== {16'h0, 3'b001}) begin n_err++; $display("FAIL reset_res: got %h %b%b%b want 0 001", res, cout, aeb, zero); end
    n_vec++; if ({alu_a, alu_b, alu_s, alu_m, alu_cnb} !== 14'h0001) begin n_err++; $display("FAIL reset_alu: got %h want 0001", {alu_a, alu_b, alu_s, alu_m, alu_cnb}); end
    rst = 1'b0; start = 1'b0; res_ack = 1'b0;
    step();
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_release: got %b want 1", ready); end
  endtask

  task automatic test_add();
    do_op(16'h1234, 16'h0FCC, 4'b1001, 1'b0, 1'b0, 1'b1);
    n_vec++; if ({res, cout, zero} !== {16'h2200, 2'b00}) begin n_err++; $display("FAIL add_const: got %h %b%b want 2200 00", res, cout, zero); end
    do_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1);
    n_vec++; if ({res, cout, zero} !== {16'h0000, 2'b11}) begin n_err++; $display("FAIL add_ovf_const: got %h %b%b want 0000 11", res, cout, zero); end
  endtask

  task automatic test_subtract();
    do_op(16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b1, 1'b1);
    n_vec++; if ({res, cout} !== {16'h4FFF, 1'b1}) begin n_err++; $display("FAIL sub_const: got %h %b want 4fff 1", res, cout); end
    do_op(16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b0, 1'b1);
    n_vec++; if ({res, aeb} !== {16'hFFFF, 1'b1}) begin n_err++; $display("FAIL sub_aeb_const: got %h %b want ffff 1", res, aeb); end
  endtask

  task automatic test_logic_xor();
    do_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 1'b1);
    n_vec++; if ({res, cout, aeb} !== {16'h0FF0, 2'b00}) begin n_err++; $display("FAIL xor_const: got %h %b%b want 0ff0 00", res, cout, aeb); end
  endtask

  task automatic test_handshake();
    logic [W-1:0] held;
    do_op(16'hA5A5, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0);
    held = exp_res;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a_in = 16'h0F0F; b_in = 16'h0101; start = 1'b1; end
      step();
      start = 1'b0;
      n_vec++; if ({ready, res_valid} !== 2'b01) begin n_err++; $display("FAIL hold_hs c=%0d: got ready=%b valid=%b want 0/1", i, ready, res_valid); end
      n_vec++; if (res !== held) begin n_err++; $display("FAIL hold_res c=%0d: got %h want %h", i, res, held); end
    end
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    n_vec++; if ({ready, res_valid} !== 2'b10) begin n_err++; $display("FAIL ack_release: got ready=%b valid=%b want 1/0", ready, res_valid); end
    step();
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL start_not_queued: got %b want 1", ready); end
    n_vec++; if (res !== held) begin n_err++; $display("FAIL idle_res_hold: got %h want %h", res, held); end
  endtask

  task automatic test_reset_mid_run();
    a_in = 16'h1234; b_in = 16'h0FCC; s_in = 4'b1001; m_in = 1'b0; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1; res_ack = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; res_ack = 1'b0; start = 1'b0;
    n_vec++; if ({ready, res_valid} !== 2'b10) begin n_err++; $display("FAIL midrst_hs: got ready=%b valid=%b want 1/0", ready, res_valid); end
    n_vec++; if ({res, alu_cnb, zero} !== {16'h0, 2'b11}) begin n_err++; $display("FAIL midrst_res: got %h %b%b want 0 11", res, alu_cnb, zero); end
    step();
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_valid: got %b want 0", res_valid); end
    do_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b1);
    n_vec++; if (res !== 16'h0002) begin n_err++; $display("FAIL midrst_add: got %h want 0002", res); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_op(W'($urandom), W'($urandom), 4'b1001, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract();
    test_logic_xor();
    test_handshake();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu181_nibble_seq.md
# alu181_nibble_seq

Sequencer that drives the team's 4-bit 74181-compatible ALU slice to perform one NIBBLES×4-bit operation, one nibble per clock, least-significant nibble first. It latches operands and function code on a start handshake. It chains the active-low carry from each nibble into the next and assembles the result. It presents the result, carry and flags through a valid/ack handshake. The block sits between the register/control logic and a single shared ALU slice.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES; legal range 2..8.
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request to begin an operation; accepted only when ready=1.
- ready  out  1  high in IDLE only.
- a_in, b_in  in  W  operands, sampled on the accepting edge.
- s_in  in  4  74181 function select, sampled with operands.
- m_in  in  1  mode: 1 = logic, 0 = arithmetic.
- cin  in  1  active-high carry-in, sampled with operands.
- alu_a, alu_b  out  4  current operand nibbles to the ALU.
- alu_s  out  4  latched function select.
- alu_m  out  1  latched mode.
- alu_cnb  out  1  active-low carry-in to the ALU.
- alu_f  in  4  ALU result nibble.
- alu_cn4b  in  1  ALU active-low carry-out.
- alu_aeb  in  1  ALU A=B output (all F bits high).
- res  out  W  assembled result.
- cout  out  1  active-high carry-out.
- aeb  out  1  AND of all nibble alu_aeb samples.
- zero  out  1  high when res == 0.
- res_valid  out  1  result available.
- res_ack  in  1  consumer accepts the result.

## Operation
- FSM states: IDLE, RUN, DONE. A nibble index k (0..NIBBLES-1) is valid in RUN.
- IDLE: ready=1. On start=1, latch a_in, b_in, s_in, m_in and cin. Set k=0 and go to RUN.
- RUN, nibble k:
  - alu_a = a_lat[4k+3:4k] and alu_b = b_lat[4k+3:4k].
  - For k=0, alu_cnb = ~cin_lat. For k>0, alu_cnb = the carry register, which holds alu_cn4b sampled at the end of nibble k-1.
- RUN, end of each cycle:
  - res[4k+3:4k] <= alu_f.
  - The carry register <= alu_cn4b.
  - aeb_acc <= aeb_acc & alu_aeb, where aeb_acc is set to 1 on start accept.
  - At k=NIBBLES-1, go to DONE. Otherwise k <= k+1.
- DONE:
  - res_valid=1.
  - res, aeb and zero are stable.
  - cout = ~carry register when m=0; cout = 0 when m=1.
  - On res_ack=1, go to IDLE.
- alu_s and alu_m always reflect the latched values. Carry is chained in logic mode too; the ALU ignores it there.
- Outside RUN: alu_a = alu_b = 0 and alu_cnb = 1.
- start outside IDLE is ignored, not queued. res_ack outside DONE is ignored.
- res, cout, aeb and zero hold their values from DONE through IDLE. They change only once the next operation's RUN begins.
- Reset values:
  - State IDLE, k=0, ready=1, res_valid=0.
  - res=0, cout=0, aeb=0, zero=1.
  - alu_a=alu_b=0, alu_s=0, alu_m=0, alu_cnb=1.
  - Operand and carry registers 0.

## Timing
- Start accepted at edge T. RUN occupies cycles T..T+NIBBLES-1. res_valid rises after edge T+NIBBLES.
- Latency from start to res_valid is NIBBLES+1 edges.
- The ALU path is combinational within one cycle: alu_* out to alu_f/alu_cn4b in.
- res_ack sampled high in DONE: res_valid=0 and ready=1 after that edge.
- The next start can be accepted on the edge after that. Throughput is one operation per NIBBLES+2 cycles minimum.
- res_ack tied high: DONE lasts exactly one cycle.
- rst=1 in any state, including mid-RUN:
  - The next edge forces all reset values.
  - The partial result is discarded and no res_valid is produced.
  - rst has priority over start and res_ack on the same edge.

## Test plan
Bench connects the block to the team's 74181 slice; NIBBLES=4 unless stated.
- Add, S=1001, M=0, cin=0: a=0x1234, b=0x0FCC -> res=0x2200, cout=0, zero=0. res_valid rises exactly 5 edges after start.
- Add overflow, S=1001, M=0, cin=0: a=0xFFFF, b=0x0001 -> res=0x0000, cout=1, zero=1. The carry must ripple through all nibbles.
- Subtract, S=0110, M=0, cin=1: a=0x5000, b=0x0001 -> res=0x4FFF, cout=1. Then cin=0 with a=b=0x3C3C -> res=0xFFFF, aeb=1.
- Logic XOR, S=0110, M=1: a=0xF0F0, b=0xFF00 -> res=0x0FF0, cout=0, aeb=0. Check alu_m=1 throughout RUN.
- Handshake: hold res_ack=0 for 5 cycles and pulse start in DONE -> res_valid stays 1, res unchanged, ready=0, start ignored. res_ack=1 -> ready=1 next cycle.
- Reset in RUN at k=2 -> next cycle ready=1, res_valid=0, res=0, alu_cnb=1. A following add 0x0001+0x0001 gives 0x0002.
